// File: rtl/opnd_launch_arb.sv
// rtl/opnd_launch_arb.sv - two-requester round-robin operand launcher with setup/capture/hold windows
//
// Purpose: grants one of two requesters at a time, drives its operand pair
// onto a shared combinational datapath, keeps the pair stable for SETUP_CYC
// cycles, captures dp_out in a single CAPTURE cycle, keeps the pair stable
// for HOLD_CYC more cycles, then presents the captured result with the
// requester id until the consumer accepts it.
//
// Optional build macro: OPND_LAUNCH_STAB_CHK_EN
//   defined   - dp_out is checked against the value seen on the last setup
//               cycle during CAPTURE and HOLD; any difference sets the sticky
//               stab_err flag.
//   undefined - stab_err is tied low and no checker logic exists.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req0_valid/a/b, req0_ready requester 0 operand handshake
//   req1_valid/a/b, req1_ready requester 1 operand handshake
//   drv_a, drv_b, drv_active   operand pair driven onto the datapath
//   dp_out                     datapath result
//   cap_stb                    high during the capture cycle
//   rsp_valid/id/data          captured result, rsp_ready accepts it
//   stab_err                   sticky datapath stability error
module opnd_launch_arb #(
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0_valid,
    input  logic req0_a,
    input  logic req0_b,
    output logic req0_ready,
    input  logic req1_valid,
    input  logic req1_a,
    input  logic req1_b,
    output logic req1_ready,
    output logic drv_a,
    output logic drv_b,
    output logic drv_active,
    input  logic dp_out,
    output logic cap_stb,
    output logic rsp_valid,
    output logic rsp_id,
    output logic rsp_data,
    input  logic rsp_ready,
    output logic stab_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CAPTURE,
        S_HOLD,
        S_RESP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rr_ptr, rr_nxt;
    logic             drv_a_nxt, drv_b_nxt, drv_active_nxt;
    logic             cap_stb_nxt, rsp_valid_nxt, rsp_id_nxt, rsp_data_nxt;
    logic             sel;
    logic             grant;

    // rr_ptr == 0 prefers requester 0. Ready is gated by rst_n so that no
    // handshake can be reported while the block is held in reset.
    always_comb begin
        sel        = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        grant      = rst_n && (state == S_IDLE) && (req0_valid || req1_valid);
        req0_ready = grant && !sel;
        req1_ready = grant && sel;
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        rr_nxt         = rr_ptr;
        drv_a_nxt      = drv_a;
        drv_b_nxt      = drv_b;
        drv_active_nxt = drv_active;
        cap_stb_nxt    = 1'b0;
        rsp_valid_nxt  = rsp_valid;
        rsp_id_nxt     = rsp_id;
        rsp_data_nxt   = rsp_data;
        case (state)
            S_IDLE: begin
                if (grant) begin
                    drv_a_nxt      = sel ? req1_a : req0_a;
                    drv_b_nxt      = sel ? req1_b : req0_b;
                    drv_active_nxt = 1'b1;
                    rsp_id_nxt     = sel;
                    cnt_nxt        = CNT_W'(SETUP_CYC - 1);
                    state_nxt      = S_SETUP;
                    // Pointer only moves when there was real contention.
                    if (req0_valid && req1_valid) begin
                        rr_nxt = !sel;
                    end
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    cap_stb_nxt = 1'b1;
                    state_nxt   = S_CAPTURE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                rsp_data_nxt = dp_out;
                if (HOLD_CYC == 0) begin
                    drv_a_nxt      = 1'b0;
                    drv_b_nxt      = 1'b0;
                    drv_active_nxt = 1'b0;
                    rsp_valid_nxt  = 1'b1;
                    state_nxt      = S_RESP;
                end else begin
                    cnt_nxt   = CNT_W'(HOLD_CYC - 1);
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    drv_a_nxt      = 1'b0;
                    drv_b_nxt      = 1'b0;
                    drv_active_nxt = 1'b0;
                    rsp_valid_nxt  = 1'b1;
                    state_nxt      = S_RESP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            rr_ptr     <= 1'b0;
            drv_a      <= 1'b0;
            drv_b      <= 1'b0;
            drv_active <= 1'b0;
            cap_stb    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rr_ptr     <= rr_nxt;
            drv_a      <= drv_a_nxt;
            drv_b      <= drv_b_nxt;
            drv_active <= drv_active_nxt;
            cap_stb    <= cap_stb_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_id     <= rsp_id_nxt;
            rsp_data   <= rsp_data_nxt;
        end
    end

`ifdef OPND_LAUNCH_STAB_CHK_EN
    logic ref_val;
    logic err_q;

    // Reference is the datapath output seen on the final setup cycle; any
    // later change while the operands are supposed to be frozen is an error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_val <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state == S_SETUP && cnt == '0) begin
                ref_val <= dp_out;
            end
            if ((state == S_CAPTURE || state == S_HOLD) && (dp_out != ref_val)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign stab_err = err_q;
`else
    assign stab_err = 1'b0;
`endif

endmodule

// File: tb/tb_opnd_launch_arb.sv
// tb/tb_opnd_launch_arb.sv - self-checking bench for opnd_launch_arb (default and zero-hold instances)
module tb_opnd_launch_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] v0, a0, b0, v1, a1, b1, rr, gl;
    logic [1:0] rdy0, rdy1, da, db, dact, dp, cap, rv, rid, rd, se;

    assign dp[0] = (da[0] & db[0]) ^ gl[0];
    assign dp[1] = (da[1] & db[1]) ^ gl[1];

    opnd_launch_arb u0 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0[0]), .req0_a(a0[0]), .req0_b(b0[0]), .req0_ready(rdy0[0]),
        .req1_valid(v1[0]), .req1_a(a1[0]), .req1_b(b1[0]), .req1_ready(rdy1[0]),
        .drv_a(da[0]), .drv_b(db[0]), .drv_active(dact[0]), .dp_out(dp[0]),
        .cap_stb(cap[0]), .rsp_valid(rv[0]), .rsp_id(rid[0]), .rsp_data(rd[0]),
        .rsp_ready(rr[0]), .stab_err(se[0])
    );

    opnd_launch_arb #(.SETUP_CYC(1), .HOLD_CYC(0), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0[1]), .req0_a(a0[1]), .req0_b(b0[1]), .req0_ready(rdy0[1]),
        .req1_valid(v1[1]), .req1_a(a1[1]), .req1_b(b1[1]), .req1_ready(rdy1[1]),
        .drv_a(da[1]), .drv_b(db[1]), .drv_active(dact[1]), .dp_out(dp[1]),
        .cap_stb(cap[1]), .rsp_valid(rv[1]), .rsp_id(rid[1]), .rsp_data(rd[1]),
        .rsp_ready(rr[1]), .stab_err(se[1])
    );

    int vec;
    int bad;
    int cyc;
    bit chk_en;

    // Transaction-timeline model: t counts cycles since the accept edge.
    // t in 1..S is setup, S+1 is capture, up to S+1+H is hold, beyond is response.
    int   sc [2] = '{2, 1};
    int   hc [2] = '{1, 0};
    logic [1:0] m_busy, m_rr, m_a, m_b, m_rid, m_rd, m_err;
    int   m_t [2];
`ifdef OPND_LAUNCH_STAB_CHK_EN
    logic [1:0] m_ref;
`endif

    task automatic check_inst(input int i);
        logic       idle, e_r0, e_r1, e_act, e_cap, e_rv, dpv;
        logic [9:0] got, exp;
        int         last;
        last  = sc[i] + 1 + hc[i];
        idle  = rst_n && !m_busy[i];
        e_r0  = idle && v0[i] && (!v1[i] || !m_rr[i]);
        e_r1  = idle && v1[i] && (!v0[i] || m_rr[i]);
        e_act = m_busy[i] && (m_t[i] <= last);
        e_cap = m_busy[i] && (m_t[i] == sc[i] + 1);
        e_rv  = m_busy[i] && (m_t[i] > last);
        exp = {e_r0, e_r1, e_act & m_a[i], e_act & m_b[i], e_act, e_cap, e_rv, m_rid[i], m_rd[i], m_err[i]};
        got = {rdy0[i], rdy1[i], da[i], db[i], dact[i], cap[i], rv[i], rid[i], rd[i], se[i]};
        if (chk_en) begin
            vec++;
            if (got !== exp) begin
                bad++;
                $display("FAIL model u%0d cycle %0d: got %b expected %b (r0 r1 da db act cap rv id data err)",
                         i, cyc, got, exp);
            end
        end
        dpv = ((e_act & m_a[i]) & (e_act & m_b[i])) ^ gl[i];
        if (!rst_n) begin
            m_busy[i] = 1'b0; m_t[i] = 0; m_rr[i] = 1'b0; m_rid[i] = 1'b0;
            m_rd[i] = 1'b0; m_err[i] = 1'b0; m_a[i] = 1'b0; m_b[i] = 1'b0;
`ifdef OPND_LAUNCH_STAB_CHK_EN
            m_ref[i] = 1'b0;
`endif
        end else if (e_r0 || e_r1) begin
            m_busy[i] = 1'b1;
            m_t[i]    = 1;
            m_rid[i]  = e_r1;
            m_a[i]    = e_r1 ? a1[i] : a0[i];
            m_b[i]    = e_r1 ? b1[i] : b0[i];
            if (v0[i] && v1[i]) m_rr[i] = !e_r1;
        end else if (m_busy[i]) begin
`ifdef OPND_LAUNCH_STAB_CHK_EN
            if (m_t[i] == sc[i]) m_ref[i] = dpv;
            if (m_t[i] > sc[i] && m_t[i] <= last && dpv !== m_ref[i]) m_err[i] = 1'b1;
`endif
            if (m_t[i] == sc[i] + 1) m_rd[i] = dpv;
            if (e_rv) begin
                if (rr[i]) m_busy[i] = 1'b0;
            end else begin
                m_t[i]++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_inst(0);
        check_inst(1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        v0 = 2'b00; a0 = 2'b00; b0 = 2'b00;
        v1 = 2'b00; a1 = 2'b00; b1 = 2'b00;
        rr = 2'b11; gl = 2'b00;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (12) tick();
    endtask

    task automatic test_reset();
        chk_en = 1'b0;
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vec++;
            if ({da[i], db[i], dact[i], cap[i], rv[i], rid[i], rd[i], se[i]} !== 8'b0) begin
                bad++;
                $display("FAIL reset_outputs u%0d: got %b expected 00000000", i,
                         {da[i], db[i], dact[i], cap[i], rv[i], rid[i], rd[i], se[i]});
            end
        end
    endtask

    task automatic test_single();
        int first_rv;
        first_rv = -1;
        idle_inputs();
        v0[0] = 1'b1; a0[0] = 1'b1; b0[0] = 1'b1;
        #1;
        vec++;
        if (rdy0[0] !== 1'b1) begin
            bad++; $display("FAIL single_ready0: got %b expected 1", rdy0[0]);
        end
        tick();
        v0[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            vec++;
            if (cap[0] !== (k == 3)) begin
                bad++; $display("FAIL single_cap_stb cycle %0d: got %b expected %b", k, cap[0], (k == 3));
            end
            vec++;
            if ({da[0], db[0], dact[0]} !== ((k <= 4) ? 3'b111 : 3'b000)) begin
                bad++; $display("FAIL single_drive cycle %0d: got %b expected %b", k,
                                {da[0], db[0], dact[0]}, ((k <= 4) ? 3'b111 : 3'b000));
            end
            if (rv[0] && first_rv < 0) begin
                first_rv = k;
                vec++;
                if ({rid[0], rd[0]} !== 2'b01) begin
                    bad++; $display("FAIL single_rsp: got id/data %b expected 01", {rid[0], rd[0]});
                end
            end
            tick();
        end
        vec++;
        if (first_rv != 5) begin
            bad++; $display("FAIL single_rsp_cycle: got %0d expected 5", first_rv);
        end
    endtask

    task automatic test_contention();
        int g[$];
        int rsp[$];
        int gcode, rcode;
        rst_n = 1'b0;
        idle_inputs();
        tick();
        rst_n = 1'b1;
        v0[0] = 1'b1; a0[0] = 1'b1; b0[0] = 1'b0;
        v1[0] = 1'b1; a1[0] = 1'b1; b1[0] = 1'b1;
        for (int k = 0; k < 40 && g.size() < 3; k++) begin
            #1;
            if (rdy0[0]) g.push_back(0);
            if (rdy1[0]) g.push_back(1);
            if (rv[0]) rsp.push_back(int'({rid[0], rd[0]}));
            tick();
        end
        idle_inputs();
        gcode = (g.size() >= 3) ? g[0] * 100 + g[1] * 10 + g[2] : -1;
        vec++;
        if (gcode != 10) begin
            bad++; $display("FAIL contention_grant_order: got %0d expected 10 (digits = ids)", gcode);
        end
        rcode = (rsp.size() >= 2) ? rsp[0] * 10 + rsp[1] : -1;
        vec++;
        if (rcode != 3) begin
            bad++; $display("FAIL contention_responses: got %0d expected 3 ({id,data} pairs 0 then 3)", rcode);
        end
    endtask

    task automatic test_backpressure();
        drain();
        v0[0] = 1'b1; a0[0] = 1'b1; b0[0] = 1'b1; rr[0] = 1'b0;
        #1;
        vec++;
        if (rdy0[0] !== 1'b1) begin
            bad++; $display("FAIL bp_grant: got %b expected 1", rdy0[0]);
        end
        tick();
        v0[0] = 1'b0;
        v1[0] = 1'b1;
        for (int k = 0; k < 20 && rv[0] !== 1'b1; k++) tick();
        vec++;
        if (rv[0] !== 1'b1) begin
            bad++; $display("FAIL bp_rsp_timeout: got rsp_valid %b expected 1", rv[0]);
        end
        for (int k = 0; k < 6; k++) begin
            #1;
            vec++;
            if ({rv[0], rid[0], rd[0], rdy0[0], rdy1[0]} !== 5'b10100) begin
                bad++; $display("FAIL bp_hold cycle %0d: got %b expected 10100 (rv id data r0 r1)", k,
                                {rv[0], rid[0], rd[0], rdy0[0], rdy1[0]});
            end
            tick();
        end
        rr[0] = 1'b1;
        tick();
        vec++;
        if ({rv[0], rdy1[0]} !== 2'b01) begin
            bad++; $display("FAIL bp_idle_reentry: got %b expected 01 (rv r1)", {rv[0], rdy1[0]});
        end
        idle_inputs();
    endtask

    task automatic test_zero_hold();
        drain();
        v0[1] = 1'b1; a0[1] = 1'b1; b0[1] = 1'b1;
        #1;
        vec++;
        if (rdy0[1] !== 1'b1) begin
            bad++; $display("FAIL zh_grant: got %b expected 1", rdy0[1]);
        end
        tick();
        v0[1] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            vec++;
            if (cap[1] !== (k == 2)) begin
                bad++; $display("FAIL zh_cap_stb cycle %0d: got %b expected %b", k, cap[1], (k == 2));
            end
            vec++;
            if ({rv[1], rv[1] & rd[1]} !== ((k == 3) ? 2'b11 : 2'b00)) begin
                bad++; $display("FAIL zh_rsp cycle %0d: got %b expected %b", k,
                                {rv[1], rv[1] & rd[1]}, ((k == 3) ? 2'b11 : 2'b00));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_setup();
        drain();
        v0[0] = 1'b1; v1[0] = 1'b1; a1[0] = 1'b1; b1[0] = 1'b1;
        #1;
        vec++;
        if ({rdy0[0], rdy1[0]} !== 2'b01) begin
            bad++; $display("FAIL rst_pre_grant: got %b expected 01 (r0 r1)", {rdy0[0], rdy1[0]});
        end
        tick();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vec++;
        if ({da[0], db[0], dact[0], cap[0], rv[0], rid[0], rd[0], se[0]} !== 8'b0) begin
            bad++; $display("FAIL rst_mid_outputs: got %b expected 00000000",
                            {da[0], db[0], dact[0], cap[0], rv[0], rid[0], rd[0], se[0]});
        end
        for (int k = 0; k < 8; k++) begin
            vec++;
            if (rv[0] !== 1'b0) begin
                bad++; $display("FAIL rst_no_rsp cycle %0d: got %b expected 0", k, rv[0]);
            end
            tick();
        end
        v0[0] = 1'b1; v1[0] = 1'b1;
        #1;
        vec++;
        if ({rdy0[0], rdy1[0]} !== 2'b10) begin
            bad++; $display("FAIL rst_rr_reset: got %b expected 10 (r0 r1)", {rdy0[0], rdy1[0]});
        end
        tick();
        drain();
    endtask

    task automatic test_stab();
        logic exp_se;
`ifdef OPND_LAUNCH_STAB_CHK_EN
        exp_se = 1'b1;
`else
        exp_se = 1'b0;
`endif
        drain();
        v0[0] = 1'b1; a0[0] = 1'b1; b0[0] = 1'b1;
        tick();
        v0[0] = 1'b0;
        repeat (3) tick();
        gl[0] = 1'b1;
        tick();
        gl[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            vec++;
            if (se[0] !== exp_se) begin
                bad++; $display("FAIL stab_err cycle %0d: got %b expected %b", k, se[0], exp_se);
            end
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vec++;
        if (se[0] !== 1'b0) begin
            bad++; $display("FAIL stab_err_reset: got %b expected 0", se[0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 2; i++) begin
                v0[i] = ($urandom_range(0, 2) != 0);
                v1[i] = ($urandom_range(0, 2) != 0);
                a0[i] = 1'($urandom);
                b0[i] = 1'($urandom);
                a1[i] = 1'($urandom);
                b1[i] = 1'($urandom);
                rr[i] = ($urandom_range(0, 3) != 0);
            end
            rst_n = ($urandom_range(0, 119) != 0);
            tick();
        end
        rst_n = 1'b1;
        drain();
    endtask

    initial begin
        vec = 0; bad = 0; cyc = 0; chk_en = 1'b0;
        m_busy = '0; m_rr = '0; m_a = '0; m_b = '0; m_rid = '0; m_rd = '0; m_err = '0;
        m_t[0] = 0; m_t[1] = 0;
`ifdef OPND_LAUNCH_STAB_CHK_EN
        m_ref = '0;
`endif
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_zero_hold();
        test_reset_mid_setup();
        test_stab();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
